// File: rtl/sobel_ram_read_arbiter_if.sv
// Avalon-MM pipelined burst read port bundle.
// The master side drives commands; the slave side returns stalls and data.
interface sobel_ram_read_arbiter_if #(
    parameter int ADD_WIDTH   = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int BE_WIDTH    = 4,
    parameter int BURST_WIDTH = 6
);
    logic [ADD_WIDTH-1:0]   address;
    logic                   read;
    logic [BURST_WIDTH-1:0] burstcount;
    logic [BE_WIDTH-1:0]    byteenable;
    logic                   waitrequest;
    logic                   readdatavalid;
    logic [DATA_WIDTH-1:0]  readdata;

    modport master (
        output address, read, burstcount, byteenable,
        input  waitrequest, readdatavalid, readdata
    );
    modport slave (
        input  address, read, burstcount, byteenable,
        output waitrequest, readdatavalid, readdata
    );
endinterface

// File: rtl/sobel_ram_read_arbiter.sv
// Two-client arbiter for the frame RAM burst read port.
// VGA scan-out (c0) has priority; the Sobel cache (c1) has a starvation guard.
module sobel_ram_read_arbiter #(
    parameter int ADD_WIDTH    = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int BE_WIDTH     = 4,
    parameter int BURST_WIDTH  = 6,
    parameter int MAX_PENDING  = 4,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    sobel_ram_read_arbiter_if.slave  c0,
    sobel_ram_read_arbiter_if.slave  c1,
    sobel_ram_read_arbiter_if.master m,
    output logic                    busy,
    output logic                    err_unexpected
);
    localparam int PW = $clog2(MAX_PENDING);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [PW:0]   FULL_CNT   = (PW + 1)'(MAX_PENDING);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [BURST_WIDTH-1:0] ONE = BURST_WIDTH'(1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                 state;
    logic                   winner;
    logic [SW-1:0]          starve_cnt;

    logic                   fifo_id    [MAX_PENDING];
    logic [BURST_WIDTH-1:0] fifo_burst [MAX_PENDING];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [PW:0]            count;
    logic                   beat_active;
    logic [BURST_WIDTH-1:0] beat_left;

    logic                   sel_read;
    logic [ADD_WIDTH-1:0]   sel_addr;
    logic [BURST_WIDTH-1:0] sel_burst;
    logic [BE_WIDTH-1:0]    sel_be;
    logic [BURST_WIDTH-1:0] eff_burst;
    logic [BURST_WIDTH-1:0] remaining;
    logic [DATA_WIDTH-1:0]  rdata;
    logic                   full;
    logic                   empty;
    logic                   req;
    logic                   pick_c1;
    logic                   accept;
    logic                   beat;
    logic                   pop;

    always_comb begin
        sel_read  = 1'b0;
        sel_addr  = '0;
        sel_burst = '0;
        sel_be    = '0;
        if (state == GRANT) begin
            if (winner) begin
                sel_read  = c1.read;
                sel_addr  = c1.address;
                sel_burst = c1.burstcount;
                sel_be    = c1.byteenable;
            end else begin
                sel_read  = c0.read;
                sel_addr  = c0.address;
                sel_burst = c0.burstcount;
                sel_be    = c0.byteenable;
            end
        end
    end

    // A zero burst would never complete a FIFO entry, so it is issued as one beat.
    assign eff_burst = (state == GRANT && sel_burst == '0) ? ONE : sel_burst;

    assign m.read       = sel_read;
    assign m.address    = sel_addr;
    assign m.burstcount = eff_burst;
    assign m.byteenable = sel_be;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign req     = c0.read | c1.read;
    assign pick_c1 = c1.read & (~c0.read | (starve_cnt == STARVE_MAX));
    assign accept  = sel_read & ~m.waitrequest;

    assign beat      = m.readdatavalid & ~empty;
    assign remaining = beat_active ? beat_left : fifo_burst[rd_ptr];
    assign pop       = beat & (remaining == ONE);

    assign c0.waitrequest   = ~(state == GRANT & ~winner) | m.waitrequest;
    assign c1.waitrequest   = ~(state == GRANT & winner) | m.waitrequest;
    assign c0.readdatavalid = beat & ~fifo_id[rd_ptr];
    assign c1.readdatavalid = beat & fifo_id[rd_ptr];

    assign rdata       = m.readdata;
    assign c0.readdata = rdata;
    assign c1.readdata = rdata;

    assign busy = (state == GRANT) | ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            winner     <= 1'b0;
            starve_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!c1.read)
                        starve_cnt <= '0;
                    if (req && !full) begin
                        state  <= GRANT;
                        winner <= pick_c1;
                        if (pick_c1)
                            starve_cnt <= '0;
                        else if (c1.read)
                            starve_cnt <= starve_cnt + 1'b1;
                    end
                end
                GRANT: begin
                    if (accept)
                        state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            fifo_id[wr_ptr]    <= winner;
            fifo_burst[wr_ptr] <= eff_burst;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            beat_active    <= 1'b0;
            beat_left      <= '0;
            err_unexpected <= 1'b0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (pop) begin
                beat_active <= 1'b0;
            end else if (beat) begin
                beat_active <= 1'b1;
                beat_left   <= remaining - 1'b1;
            end
            if (m.readdatavalid && empty)
                err_unexpected <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sobel_ram_read_arbiter.sv
// Directed bench with a transaction-level model of grants and beat routing.
// A negedge monitor checks every cycle; test threads pin literal outcomes.
module tb_sobel_ram_read_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sobel_ram_read_arbiter_if c0_if ();
    sobel_ram_read_arbiter_if c1_if ();
    sobel_ram_read_arbiter_if m_if ();
    logic busy;
    logic err_unexpected;

    sobel_ram_read_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .c0            (c0_if),
        .c1            (c1_if),
        .m             (m_if),
        .busy          (busy),
        .err_unexpected(err_unexpected)
    );

    int total = 0;
    int bad = 0;

    logic mem_en = 1'b1;
    logic mem_wait = 1'b0;
    logic mem_rdv = 1'b0;
    logic stray = 1'b0;
    logic [31:0] dctr = 32'h1000;
    assign m_if.waitrequest = mem_wait;
    assign m_if.readdatavalid = mem_rdv | stray;

    // model state
    int qid[$];
    int qleft[$];
    int mem_q[$];
    int grant_log[$];
    int exp_gnt = -1;
    int starve = 0;
    bit err_exp = 1'b0;
    int rx[2] = '{0, 0};
    int coinc = 0;
    logic [31:0] last_addr = '0;
    int osz;
    int own;
    bit acc;
    bit err_next;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic int eff(input logic [5:0] b);
        return (b == 6'd0) ? 1 : int'(b);
    endfunction

    always @(posedge clk) begin
        #1;
        if (rst || !mem_en || mem_q.size() == 0) begin
            mem_rdv = 1'b0;
        end else begin
            mem_rdv = 1'b1;
            m_if.readdata = dctr;
            dctr = dctr + 32'h11;
            mem_q[0] = mem_q[0] - 1;
            if (mem_q[0] == 0)
                void'(mem_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_m_read", m_if.read, 0);
            chk("rst_m_addr", m_if.address, 0);
            chk("rst_m_burst", m_if.burstcount, 0);
            chk("rst_m_be", m_if.byteenable, 0);
            chk("rst_c0_wr", c0_if.waitrequest, 1);
            chk("rst_c1_wr", c1_if.waitrequest, 1);
            chk("rst_c0_rdv", c0_if.readdatavalid, 0);
            chk("rst_c1_rdv", c1_if.readdatavalid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_err", err_unexpected, 0);
            qid.delete();
            qleft.delete();
            mem_q.delete();
            exp_gnt = -1;
            starve = 0;
            err_exp = 1'b0;
        end else begin
            osz = qid.size();
            acc = m_if.read && !m_if.waitrequest;
            err_next = 1'b0;
            if (exp_gnt == 0) begin
                chk("m_read", m_if.read, 1);
                chk("m_addr", m_if.address, c0_if.address);
                chk("m_burst", m_if.burstcount, eff(c0_if.burstcount));
                chk("m_be", m_if.byteenable, c0_if.byteenable);
                chk("c0_wr", c0_if.waitrequest, m_if.waitrequest);
                chk("c1_wr", c1_if.waitrequest, 1);
            end else if (exp_gnt == 1) begin
                chk("m_read", m_if.read, 1);
                chk("m_addr", m_if.address, c1_if.address);
                chk("m_burst", m_if.burstcount, eff(c1_if.burstcount));
                chk("m_be", m_if.byteenable, c1_if.byteenable);
                chk("c1_wr", c1_if.waitrequest, m_if.waitrequest);
                chk("c0_wr", c0_if.waitrequest, 1);
            end else begin
                chk("m_read_idle", m_if.read, 0);
                chk("c0_wr_idle", c0_if.waitrequest, 1);
                chk("c1_wr_idle", c1_if.waitrequest, 1);
            end
            chk("busy", busy, (exp_gnt >= 0) || (osz > 0));
            chk("c0_rdata", c0_if.readdata, m_if.readdata);
            chk("c1_rdata", c1_if.readdata, m_if.readdata);
            if (m_if.readdatavalid && osz == 0) begin
                chk("c0_rdv_stray", c0_if.readdatavalid, 0);
                chk("c1_rdv_stray", c1_if.readdatavalid, 0);
                err_next = 1'b1;
            end else if (m_if.readdatavalid) begin
                own = qid[0];
                chk("c0_rdv", c0_if.readdatavalid, own == 0);
                chk("c1_rdv", c1_if.readdatavalid, own == 1);
                rx[own]++;
                qleft[0] = qleft[0] - 1;
                if (qleft[0] == 0) begin
                    void'(qid.pop_front());
                    void'(qleft.pop_front());
                    if (acc)
                        coinc++;
                end
            end else begin
                chk("c0_rdv_idle", c0_if.readdatavalid, 0);
                chk("c1_rdv_idle", c1_if.readdatavalid, 0);
            end
            chk("err", err_unexpected, err_exp);
            if (err_next)
                err_exp = 1'b1;
            if (exp_gnt >= 0) begin
                if (acc) begin
                    own = (exp_gnt == 0) ? eff(c0_if.burstcount)
                                         : eff(c1_if.burstcount);
                    qid.push_back(exp_gnt);
                    qleft.push_back(own);
                    mem_q.push_back(own);
                    last_addr = m_if.address;
                    exp_gnt = -1;
                end
            end else begin
                if (!c1_if.read)
                    starve = 0;
                if ((c0_if.read || c1_if.read) && osz < 4) begin
                    if (c1_if.read && (!c0_if.read || starve == 16)) begin
                        exp_gnt = 1;
                        starve = 0;
                    end else begin
                        exp_gnt = 0;
                        if (c1_if.read)
                            starve++;
                    end
                    grant_log.push_back(exp_gnt);
                end
            end
        end
    end

    task automatic issue(input int id, input logic [31:0] a,
                         input logic [5:0] b, input logic [3:0] be);
        int n = 0;
        logic wr;
        if (id == 0) begin
            c0_if.address = a;
            c0_if.burstcount = b;
            c0_if.byteenable = be;
            c0_if.read = 1'b1;
        end else begin
            c1_if.address = a;
            c1_if.burstcount = b;
            c1_if.byteenable = be;
            c1_if.read = 1'b1;
        end
        do begin
            @(negedge clk);
            n++;
            wr = (id == 0) ? c0_if.waitrequest : c1_if.waitrequest;
        end while (wr && n < 300);
        if (wr) begin
            total++;
            bad++;
            $display("FAIL issue_timeout: client %0d addr %0h not accepted",
                     id, a);
        end
        @(posedge clk);
        #1;
        if (id == 0)
            c0_if.read = 1'b0;
        else
            c1_if.read = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((qid.size() != 0 || mem_q.size() != 0) && n < 1000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 1000) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: pending=%0d required 0",
                     qid.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int b0;
        int b1;
        int c;
        int pos;
        c0_if.read = 1'b0;
        c0_if.address = '0;
        c0_if.burstcount = '0;
        c0_if.byteenable = '0;
        c1_if.read = 1'b0;
        c1_if.address = '0;
        c1_if.burstcount = '0;
        c1_if.byteenable = '0;
        m_if.readdata = '0;
        repeat (3) @(negedge clk);
        chk("p_rst_busy", busy, 0);
        chk("p_rst_wr", c0_if.waitrequest & c1_if.waitrequest, 1);
        @(posedge clk);
        #1 rst = 1'b0;

        // T1: lone c1 burst with a two-cycle command stall
        b0 = rx[0];
        b1 = rx[1];
        mem_wait = 1'b1;
        fork
            issue(1, 32'h100, 6'd8, 4'hF);
            begin
                repeat (3) @(negedge clk);
                @(posedge clk);
                #1 mem_wait = 1'b0;
            end
        join
        drain();
        chk("t1_c1_beats", rx[1] - b1, 8);
        chk("t1_c0_beats", rx[0] - b0, 0);
        chk("t1_addr", last_addr, 32'h100);

        // T2: simultaneous requests, c1 with burstcount 0
        g = grant_log.size();
        b0 = rx[0];
        b1 = rx[1];
        fork
            issue(0, 32'h2000, 6'd4, 4'h3);
            issue(1, 32'h3000, 6'd0, 4'hC);
        join
        drain();
        chk("t2_first", grant_log[g], 0);
        chk("t2_second", grant_log[g + 1], 1);
        chk("t2_c0_beats", rx[0] - b0, 4);
        chk("t2_c1_beats", rx[1] - b1, 1);

        // T3: c0 hogs the port while c1 waits
        g = grant_log.size();
        fork
            begin
                for (int i = 0; i < 20; i++)
                    issue(0, 32'h4000 + 32'(i * 4), 6'd1, 4'hF);
            end
            issue(1, 32'h5000, 6'd1, 4'hF);
        join
        drain();
        pos = -1;
        for (int i = g; i < grant_log.size(); i++)
            if (grant_log[i] == 1 && pos < 0)
                pos = i - g;
        chk("t3_c1_slot", pos, 16);

        // T4: responses stalled until four bursts are pending
        mem_en = 1'b0;
        for (int i = 0; i < 4; i++)
            issue(1, 32'h6000 + 32'(i * 64), 6'd2, 4'hF);
        fork
            issue(1, 32'h7000, 6'd2, 4'hF);
            begin
                repeat (6) @(negedge clk);
                #1;
                chk("t4_hold_wr", c1_if.waitrequest, 1);
                chk("t4_hold_mread", m_if.read, 0);
                chk("t4_pending", qid.size(), 4);
                chk("t4_busy", busy, 1);
                mem_en = 1'b1;
            end
        join
        drain();
        chk("t4_last_addr", last_addr, 32'h7000);

        // T5: last beat of A lands on the accept cycle of E
        mem_en = 1'b0;
        b0 = rx[0];
        b1 = rx[1];
        issue(1, 32'h8000, 6'd2, 4'hF);
        mem_wait = 1'b1;
        c = coinc;
        fork
            issue(0, 32'h9000, 6'd3, 4'h5);
            begin
                repeat (3) @(negedge clk);
                mem_en = 1'b1;
                @(posedge clk);
                @(posedge clk);
                #2 mem_wait = 1'b0;
            end
        join
        chk("t5_coincide", coinc - c, 1);
        chk("t5_pending", qid.size(), 1);
        drain();
        chk("t5_c1_beats", rx[1] - b1, 2);
        chk("t5_c0_beats", rx[0] - b0, 3);

        // T6: stray beat with nothing outstanding
        b0 = rx[0];
        b1 = rx[1];
        @(posedge clk);
        #1 stray = 1'b1;
        @(posedge clk);
        #1 stray = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_err_set", err_unexpected, 1);
        chk("t6_no_beats", (rx[0] - b0) + (rx[1] - b1), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("t6_err_rst", err_unexpected, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_err_after", err_unexpected, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
